csa_wide_seq_adder: RTL and testbench
=====================================

Name: csa_wide_seq_adder

Overview:
- Sequential wide-operand adder that sits directly upstream of the 16-bit carry-select adder, c_select16bit.
- Latches two WIDTH-bit operands through a valid/ready handshake.
- Feeds them to one c_select16bit instance one 16-bit chunk per cycle, least-significant chunk first, chaining the carry through a register.
- Presents the full WIDTH-bit sum and carry-out through a valid/ready output handshake.

Parameters:
- WIDTH, 64, operand/sum width; must be a multiple of 16 and at least 16 (elaboration-time check).
- NCHUNK, WIDTH/16, derived number of chunk cycles; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to chunk 0.
- out_valid  output  1  sum and cout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock domain. rst is sampled only on the rising clk edge and takes priority over every other event.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, chunk index=0, carry register=0.
- Internal state:
  - a_sh and b_sh: operand shift registers.
  - c_reg: chunk carry register.
  - idx: chunk counter, width clog2(NCHUNK)+1.
  - s_acc: sum accumulator.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a->a_sh, b->b_sh, cin->c_reg, idx=0, go to RUN.
  - Inputs are ignored when in_valid=0.
- RUN:
  - in_ready=0.
  - The adder sees a_sh[15:0], b_sh[15:0] and c_reg combinationally.
  - Each edge:
    - s_acc <= {adder_sum, s_acc[WIDTH-1:16]} (fill from the top).
    - a_sh and b_sh shift right by 16.
    - c_reg <= adder_cout.
    - idx increments.
  - On the edge where idx==NCHUNK-1: go to DONE, and load sum<=final s_acc and cout<=final adder_cout.
- DONE:
  - out_valid=1. sum and cout are held stable while out_ready=0 (backpressure for any number of cycles).
  - On out_valid&out_ready: go to IDLE, out_valid=0. sum and cout keep their last value.
  - in_ready stays 0 in DONE, so the same-cycle accept is the following cycle at the earliest.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. Minimum issue interval is NCHUNK+2 cycles.
- Arithmetic:
  - Unsigned. Carry is chained exactly; the result equals the full (WIDTH+1)-bit a+b+cin.
  - Overflow of the maximum value wraps: sum=0 with cout=1 for all-ones + 0 + cin=1.
- Reset mid-RUN or mid-DONE: the operation is discarded and there is no out_valid pulse. The next cycle is IDLE with in_ready=1.
- WIDTH=16 (NCHUNK=1): RUN lasts one cycle, which is still legal.

Optional Feature:
- Macro CSA_SEQ_OVERFLOW_EN.
- When defined:
  - Extra output port ovf (1 bit) = signed two's-complement overflow = carry into bit WIDTH-1 XOR cout.
  - Computed on the final chunk (carry into bit 15 of that chunk, from a 15-bit partial add or the MSB-xor identity: a[W-1]^b[W-1]^sum[W-1]^cout).
  - Registered alongside cout, reset to 0, held with sum in DONE.
- When undefined: no ovf port and no associated logic.

Decomposition:
- Shared package csa_pkg:
  - CHUNK_W=16.
  - State enum typedef csa_seq_state_t {IDLE, RUN, DONE}.
  - Function chunks(width) returning width/CHUNK_W.
- Sub-module: reuse the existing c_select16bit as the single chunk datapath. No new sub-module is needed.

Test Plan:
- Reset/idle: hold rst 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Basic add, WIDTH=64: a=2, b=2, cin=1 -> out_valid exactly 4 cycles after the accept edge, sum=5, cout=0.
- Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. With CSA_SEQ_OVERFLOW_EN, ovf=0.
- Signed overflow and chunk boundaries:
  - a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
  - a=64'h0000_FFFF_0000_FFFF, b=64'h0000_0001_0000_0001 -> sum=64'h0001_0000_0001_0000.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle.
- Reset mid-RUN: assert rst 2 cycles after accepting a=100, b=12 -> no out_valid pulse. Next op a=12, b=3, cin=1 -> sum=16.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the sequential wide adder built around c_select16bit.
package csa_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } csa_seq_state_t;

    function automatic int chunks(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/c_select16bit.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputed for carry-in 0 and 1.
module c_select16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [4:0]      c;
    logic [3:0][3:0] s0;
    logic [3:0][3:0] s1;
    logic [3:0]      co0;
    logic [3:0]      co1;

    assign c[0] = cin;

    for (genvar g = 0; g < 4; g++) begin : g_blk
        assign {co0[g], s0[g]} = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign {co1[g], s1[g]} = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
        assign sum[4*g +: 4]   = c[g] ? s1[g] : s0[g];
        assign c[g+1]          = c[g] ? co1[g] : co0[g];
    end

    assign cout = c[4];

endmodule

// File: rtl/csa_wide_seq_adder.sv
// Sequential WIDTH-bit adder: one 16-bit chunk per cycle through c_select16bit, LSB chunk first.
// Optional signed-overflow output ovf enabled by defining CSA_SEQ_OVERFLOW_EN.
module csa_wide_seq_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CSA_SEQ_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NCHUNK = chunks(WIDTH);
    localparam int IDX_W  = $clog2(NCHUNK) + 1;

    if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_bad_width
        $error("csa_wide_seq_adder: WIDTH must be a positive multiple of 16");
    end

    csa_seq_state_t   state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_acc_q, s_acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             c_reg_q, c_reg_d;
    logic             cout_q, cout_d;
`ifdef CSA_SEQ_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic [15:0]      add_sum;
    logic             add_cout;
    logic             last_chunk;
    logic [WIDTH-1:0] s_acc_next;

    c_select16bit u_chunk (
        .a    (a_sh_q[15:0]),
        .b    (b_sh_q[15:0]),
        .cin  (c_reg_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
    // Shift the new chunk in at the top; the concat form also covers WIDTH == 16.
    assign s_acc_next = WIDTH'({add_sum, s_acc_q} >> CHUNK_W);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_acc_d = s_acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        c_reg_d = c_reg_q;
        cout_d  = cout_q;
`ifdef CSA_SEQ_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_reg_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> CHUNK_W;
                b_sh_d  = b_sh_q >> CHUNK_W;
                s_acc_d = s_acc_next;
                c_reg_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_chunk) begin
                    sum_d  = s_acc_next;
                    cout_d = add_cout;
`ifdef CSA_SEQ_OVERFLOW_EN
                    // Carry into the MSB recovered from the top bit's sum identity.
                    ovf_d  = a_sh_q[15] ^ b_sh_q[15] ^ add_sum[15] ^ add_cout;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_acc_q <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            c_reg_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CSA_SEQ_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_acc_q <= s_acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            c_reg_q <= c_reg_d;
            cout_q  <= cout_d;
`ifdef CSA_SEQ_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
        cout      = cout_q;
`ifdef CSA_SEQ_OVERFLOW_EN
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_csa_wide_seq_adder.sv
// Scoreboard bench for csa_wide_seq_adder (WIDTH=64); covers ovf when CSA_SEQ_OVERFLOW_EN is defined.
module tb_csa_wide_seq_adder;

    localparam int W   = 64;
    localparam int NCH = W / 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CSA_SEQ_OVERFLOW_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    csa_wide_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef CSA_SEQ_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    // Drive one operation, push the model result; returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        exp_t       e;
        logic [W:0] full;
        int         guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL issue_ready got=%0b want=1", in_ready);
        end
        full   = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
        sb.push_back(e);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (sum !== '0)         begin failures++; $display("FAIL reset_sum got=%h want=0", sum); end
        checks++; if (cout !== 1'b0)      begin failures++; $display("FAIL reset_cout got=%0b want=0", cout); end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [W-1:0] va[5];
        logic [W-1:0] vb[5];
        logic         vc[5];
        exp_t         e;
        int           lat;
        va[0] = 64'd2;                   vb[0] = 64'd2;                   vc[0] = 1'b1;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd0;                   vc[1] = 1'b1;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'd1;                   vc[2] = 1'b0;
        va[3] = 64'h0000_FFFF_0000_FFFF; vb[3] = 64'h0000_0001_0000_0001; vc[3] = 1'b0;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'h8000_0000_0000_0001; vc[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], vc[i]);
            wait_out(lat);
            checks++; if (lat != NCH) begin failures++; $display("FAIL arith%0d_latency got=%0d want=%0d", i, lat, NCH); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (sum !== e.sum)   begin failures++; $display("FAIL arith%0d_sum got=%h want=%h", i, sum, e.sum); end
                checks++; if (cout !== e.cout) begin failures++; $display("FAIL arith%0d_cout got=%0b want=%0b", i, cout, e.cout); end
`ifdef CSA_SEQ_OVERFLOW_EN
                checks++; if (ovf !== e.ovf)   begin failures++; $display("FAIL arith%0d_ovf got=%0b want=%0b", i, ovf, e.ovf); end
`endif
            end
            consume();
        end
        // Spot-check the scoreboard model against the hand-derived table values.
        checks++; if (e.sum !== 64'h0000_0000_0000_0002 || e.cout !== 1'b1) begin
            failures++; $display("FAIL arith_model_last got=%h/%0b want=2/1", e.sum, e.cout);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        issue(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0);
        wait_out(lat);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            checks++; if (sum !== e.sum || cout !== e.cout) begin
                failures++; $display("FAIL bp_hold%0d got=%h/%0b want=%h/%0b", k, sum, cout, e.sum, e.cout);
            end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++; $display("FAIL bp_hs%0d got in_ready=%0b out_valid=%0b want 0/1", k, in_ready, out_valid);
            end
            @(negedge clk);
        end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_release got in_ready=%0b out_valid=%0b busy=%0b want 1/0/0", in_ready, out_valid, busy);
        end
        checks++; if (sum !== e.sum) begin failures++; $display("FAIL bp_sum_kept got=%h want=%h", sum, e.sum); end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   lat;
        int   pulses = 0;
        issue(64'd100, 64'd12, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_run_idle got in_ready=%0b busy=%0b want 1/0", in_ready, busy);
        end
        repeat (6) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rst_run_pulse got=%0d want=0", pulses); end
        issue(64'd12, 64'd3, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        checks++; if (lat != NCH)      begin failures++; $display("FAIL rst_next_latency got=%0d want=%0d", lat, NCH); end
        checks++; if (sum !== 64'd16)  begin failures++; $display("FAIL rst_next_sum got=%h want=16", sum); end
        checks++; if (sum !== e.sum || cout !== e.cout) begin
            failures++; $display("FAIL rst_next_model got=%h/%0b want=%h/%0b", sum, cout, e.sum, e.cout);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        int           lat;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            issue(ra, rb, 1'($urandom_range(1)));
            wait_out(lat);
            e = sb.pop_front();
            checks++; if (lat != NCH || sum !== e.sum || cout !== e.cout) begin
                failures++; $display("FAIL rand%0d got lat=%0d %h/%0b want lat=%0d %h/%0b", i, lat, sum, cout, NCH, e.sum, e.cout);
            end
`ifdef CSA_SEQ_OVERFLOW_EN
            checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL rand%0d_ovf got=%0b want=%0b", i, ovf, e.ovf); end
`endif
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
